// File: rtl/bcd_ascii_pkg.sv
// Shared constants, state encoding and digit-to-ASCII mapping for the BCD ASCII emitter.
package bcd_ascii_pkg;

  localparam logic [7:0] ASCII_ZERO    = 8'h30;
  localparam logic [7:0] ASCII_INVALID = 8'h3F;
  localparam logic [7:0] ASCII_CR      = 8'h0D;
  localparam logic [7:0] ASCII_LF      = 8'h0A;

  typedef enum logic [1:0] {
    IDLE   = 2'd0,
    EMIT   = 2'd1,
    TERM   = 2'd2,
    FINISH = 2'd3
  } state_e;

  // Non-decimal codes from a glitched counter show up as '?' rather than garbage.
  function automatic logic [7:0] bcd2ascii(input logic [3:0] digit);
    if (digit <= 4'd9) begin
      return ASCII_ZERO + {4'h0, digit};
    end
    return ASCII_INVALID;
  endfunction

endpackage

// File: rtl/bcd_lead_digit_finder.sv
// Combinational priority encoder: position of the most significant nonzero BCD digit
// (0 when every digit is zero, so a lone '0' is still printed).
module bcd_lead_digit_finder #(
  parameter int DIGITS = 8,
  parameter int IDX_W  = (DIGITS > 1) ? $clog2(DIGITS) : 1
) (
  input  logic [4*DIGITS-1:0] digits_i,
  output logic [IDX_W-1:0]    leadIdx_o
);

  // Ascending scan so the highest nonzero digit wins.
  always_comb begin
    leadIdx_o = '0;
    for (int i = 0; i < DIGITS; i++) begin
      if (digits_i[4*i +: 4] != 4'h0) begin
        leadIdx_o = i[IDX_W-1:0];
      end
    end
  end

endmodule

// File: rtl/bcd_ascii_emitter.sv
// Snapshots packed BCD digits on start and streams them MSD-first as ASCII over valid/ready.
// Define BCD_ASCII_EMITTER_CRLF_EN to terminate every string with CR, LF.
module bcd_ascii_emitter
  import bcd_ascii_pkg::*;
#(
  parameter int DIGITS = 8
) (
  input  logic                clk,
  input  logic                rst,
  input  logic [4*DIGITS-1:0] bcd_in,
  input  logic                start,
  output logic                busy,
  output logic [7:0]          out_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic                done
);

  localparam int IDX_W = (DIGITS > 1) ? $clog2(DIGITS) : 1;

  state_e              state_q, state_d;
  logic [4*DIGITS-1:0] shadow_q, shadow_d;
  logic [IDX_W-1:0]    index_q, index_d;
  logic [IDX_W-1:0]    leadIdx;
  logic [3:0]          curDigit;
  logic                transfer;
`ifdef BCD_ASCII_EMITTER_CRLF_EN
  logic                lfPhase_q, lfPhase_d;
`endif

  bcd_lead_digit_finder #(
    .DIGITS(DIGITS),
    .IDX_W (IDX_W)
  ) u_finder (
    .digits_i (bcd_in),
    .leadIdx_o(leadIdx)
  );

  assign transfer = out_valid && out_ready;

  always_comb begin
    curDigit = shadow_q[4*index_q +: 4];
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= IDLE;
      shadow_q  <= '0;
      index_q   <= '0;
`ifdef BCD_ASCII_EMITTER_CRLF_EN
      lfPhase_q <= 1'b0;
`endif
    end else begin
      state_q   <= state_d;
      shadow_q  <= shadow_d;
      index_q   <= index_d;
`ifdef BCD_ASCII_EMITTER_CRLF_EN
      lfPhase_q <= lfPhase_d;
`endif
    end
  end

  always_comb begin
    state_d   = state_q;
    shadow_d  = shadow_q;
    index_d   = index_q;
`ifdef BCD_ASCII_EMITTER_CRLF_EN
    lfPhase_d = lfPhase_q;
`endif
    case (state_q)
      IDLE: begin
        if (start) begin
          shadow_d = bcd_in;
          index_d  = leadIdx;
          state_d  = EMIT;
        end
      end
      EMIT: begin
        if (transfer) begin
          if (index_q == '0) begin
`ifdef BCD_ASCII_EMITTER_CRLF_EN
            state_d = TERM;
`else
            state_d = FINISH;
`endif
          end else begin
            index_d = index_q - 1'b1;
          end
        end
      end
      TERM: begin
`ifdef BCD_ASCII_EMITTER_CRLF_EN
        // CR goes out first; the LF transfer closes the string.
        if (transfer) begin
          if (lfPhase_q) begin
            lfPhase_d = 1'b0;
            state_d   = FINISH;
          end else begin
            lfPhase_d = 1'b1;
          end
        end
`else
        state_d = FINISH;
`endif
      end
      FINISH: begin
        state_d = IDLE;
      end
      default: begin
        state_d = IDLE;
      end
    endcase
  end

  always_comb begin
    busy      = (state_q != IDLE);
    out_valid = 1'b0;
    out_data  = 8'h00;
    done      = 1'b0;
    case (state_q)
      EMIT: begin
        out_valid = 1'b1;
        out_data  = bcd2ascii(curDigit);
      end
      TERM: begin
`ifdef BCD_ASCII_EMITTER_CRLF_EN
        out_valid = 1'b1;
        out_data  = lfPhase_q ? ASCII_LF : ASCII_CR;
`endif
      end
      FINISH: begin
        done = 1'b1;
      end
      default: begin
      end
    endcase
  end

endmodule

// File: tb/tb_bcd_ascii_emitter.sv
// Self-checking bench for bcd_ascii_emitter (DIGITS=4): string-level reference model plus
// directed vectors with literal expectations. Honours BCD_ASCII_EMITTER_CRLF_EN.
module tb_bcd_ascii_emitter;

  logic        clk;
  logic        rst;
  logic [15:0] bcd_in;
  logic        start;
  logic        busy;
  logic [7:0]  out_data;
  logic        out_valid;
  logic        out_ready;
  logic        done;

  int assertCount = 0;
  int failCount   = 0;

  logic [7:0] expQ[$];
  logic [7:0] rxQ[$];
  bit         modelBusy = 1'b0;
  bit         modelDone = 1'b0;
  int         readyMode = 1;

  bcd_ascii_emitter #(.DIGITS(4)) dut (
    .clk      (clk),
    .rst      (rst),
    .bcd_in   (bcd_in),
    .start    (start),
    .busy     (busy),
    .out_data (out_data),
    .out_valid(out_valid),
    .out_ready(out_ready),
    .done     (done)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic void compare(input string name, input logic [31:0] act, input logic [31:0] expv);
    assertCount++;
    if (act !== expv) begin
      failCount++;
      $display("[TB] FAIL %s: got %0h expected %0h", name, act, expv);
    end
  endfunction

  // Reference: the decimal string without leading zeros, at least one digit, '?' for codes above 9.
  function automatic void buildString(input logic [15:0] bcd);
    bit started = 1'b0;
    for (int d = 3; d >= 0; d--) begin
      int digit = int'((bcd >> (4 * d)) & 16'hF);
      if (digit != 0 || d == 0) started = 1'b1;
      if (started) expQ.push_back((digit < 10) ? 8'(48 + digit) : 8'd63);
    end
`ifdef BCD_ASCII_EMITTER_CRLF_EN
    expQ.push_back(8'h0D);
    expQ.push_back(8'h0A);
`endif
  endfunction

  always @(posedge clk) begin
    #1;
    case (readyMode)
      0:       out_ready = 1'b0;
      2:       out_ready = 1'($urandom_range(0, 1));
      default: out_ready = 1'b1;
    endcase
  end

  // Every negedge: compare DUT against the model, then advance the model across the next edge.
  always @(negedge clk) begin
    bit expValid;
    bit nextDone;
    expValid = (expQ.size() != 0);
    compare("busy", 32'(busy), 32'(modelBusy));
    compare("done", 32'(done), 32'(modelDone));
    compare("out_valid", 32'(out_valid), 32'(expValid));
    if (expValid) compare("out_data", 32'(out_data), 32'(expQ[0]));
    if (rst) begin
      expQ.delete();
      modelBusy = 1'b0;
      modelDone = 1'b0;
    end else begin
      nextDone = 1'b0;
      if (out_valid && out_ready) rxQ.push_back(out_data);
      if (expValid && out_ready) begin
        void'(expQ.pop_front());
        if (expQ.size() == 0) nextDone = 1'b1;
      end
      if (!modelBusy && start) begin
        buildString(bcd_in);
        modelBusy = 1'b1;
      end else if (modelDone) begin
        modelBusy = 1'b0;
      end
      modelDone = nextDone;
    end
  end

  task automatic applyStimulus(input logic [15:0] bcd, input int mode);
    @(posedge clk);
    #1;
    rxQ.delete();
    readyMode = mode;
    bcd_in    = bcd;
    start     = 1'b1;
    @(posedge clk);
    #1;
    start  = 1'b0;
    bcd_in = ~bcd;
  endtask

  task automatic waitDone(input string name);
    bit seen = 1'b0;
    for (int c = 0; c < 300; c++) begin
      @(negedge clk);
      if (done) begin
        seen = 1'b1;
        break;
      end
    end
    compare({name, " done seen"}, 32'(seen), 32'd1);
  endtask

  task automatic checkOutput(input string name, input logic [63:0] expChars, input int len, input bit withTerm);
    logic [7:0] want[$];
    for (int k = 0; k < len; k++) want.push_back(expChars[8*(len-1-k) +: 8]);
`ifdef BCD_ASCII_EMITTER_CRLF_EN
    if (withTerm) begin
      want.push_back(8'h0D);
      want.push_back(8'h0A);
    end
`else
    if (withTerm) want.push_back(8'h00);
    if (withTerm) void'(want.pop_back());
`endif
    compare({name, " length"}, 32'(rxQ.size()), 32'(want.size()));
    for (int k = 0; k < want.size() && k < rxQ.size(); k++) begin
      compare($sformatf("%s char%0d", name, k), 32'(rxQ[k]), 32'(want[k]));
    end
  endtask

  initial begin
    logic [7:0] lit[$];
    rst       = 1'b1;
    start     = 1'b0;
    bcd_in    = 16'h0;
    out_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    compare("reset busy", 32'(busy), 32'd0);
    compare("reset out_valid", 32'(out_valid), 32'd0);
    compare("reset out_data", 32'(out_data), 32'h00);
    compare("reset done", 32'(done), 32'd0);
    @(posedge clk);
    #1;
    rst = 1'b0;

    // "420": chars on the three cycles after acceptance, done right after.
    lit = '{8'h34, 8'h32, 8'h30};
`ifdef BCD_ASCII_EMITTER_CRLF_EN
    lit.push_back(8'h0D);
    lit.push_back(8'h0A);
`endif
    applyStimulus(16'h0420, 1);
    foreach (lit[k]) begin
      @(negedge clk);
      compare($sformatf("0420 valid c%0d", k), 32'(out_valid), 32'd1);
      compare($sformatf("0420 data c%0d", k), 32'(out_data), 32'(lit[k]));
      compare($sformatf("0420 busy c%0d", k), 32'(busy), 32'd1);
    end
    @(negedge clk);
    compare("0420 done", 32'(done), 32'd1);
    compare("0420 busy at done", 32'(busy), 32'd1);
    checkOutput("0420", 64'h343230, 3, 1'b1);

    applyStimulus(16'h0000, 1);
    waitDone("0000");
    checkOutput("0000", 64'h30, 1, 1'b1);

    applyStimulus(16'h9999, 1);
    waitDone("9999");
    checkOutput("9999", 64'h39393939, 4, 1'b1);

    applyStimulus(16'h1A03, 1);
    waitDone("1A03");
    checkOutput("1A03", 64'h313F3033, 4, 1'b1);

    applyStimulus(16'h0057, 2);
    waitDone("0057");
    checkOutput("0057", 64'h3537, 2, 1'b1);

    // Second start while busy must be ignored.
    applyStimulus(16'h0420, 0);
    @(posedge clk);
    #1;
    bcd_in = 16'h1111;
    start  = 1'b1;
    @(posedge clk);
    #1;
    start     = 1'b0;
    readyMode = 1;
    waitDone("busy start");
    checkOutput("busy start", 64'h343230, 3, 1'b1);

    // Reset after two of four characters.
    applyStimulus(16'h1234, 1);
    for (int c = 0; c < 20; c++) begin
      @(posedge clk);
      #1;
      if (rxQ.size() >= 2) break;
    end
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
    @(negedge clk);
    compare("midrst busy", 32'(busy), 32'd0);
    compare("midrst out_valid", 32'(out_valid), 32'd0);
    compare("midrst done", 32'(done), 32'd0);
    checkOutput("midrst partial", 64'h3132, 2, 1'b0);
    repeat (4) @(negedge clk);
    compare("midrst no late done", 32'(done), 32'd0);

    applyStimulus(16'h0008, 1);
    waitDone("0008");
    checkOutput("0008", 64'h38, 1, 1'b1);

    repeat (3) @(posedge clk);
    $display("End of test - %0d assertions evaluated, %0d failures", assertCount, failCount);
    $finish;
  end

endmodule
